// File: rtl/one_hot_to_bin_stream.sv
// Streaming one-hot to binary decoder with a one-cycle registered, backpressured output.
// Malformed codes are flagged on the output and counted at accept time.
module one_hot_to_bin_stream #(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_W-1:0]     err_cnt_o,
  input  logic                 clr_cnt_i
);

  logic                 r_vld;
  logic [BIN_W-1:0]     r_bin;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_rdy;
  logic                 w_accept;
  logic [BIN_W-1:0]     w_bin;
  logic                 w_zero;
  logic                 w_multi;
  logic                 w_err;
  logic                 w_cnt_max;

  assign w_rdy    = !r_vld || ready_i;
  assign w_accept = valid_i && w_rdy;

  // Descending scan: the last hit written is the lowest set bit.
  always_comb begin
    w_bin = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
      if (one_hot_i[i]) begin
        w_bin = BIN_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_zero    = ~|one_hot_i;
  assign w_multi   = |(one_hot_i & (one_hot_i - ONE_HOT_W'(1)));
  assign w_err     = w_zero || w_multi;
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_bin <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_vld <= 1'b1;
      r_bin <= w_bin;
      r_err <= w_err;
    end else if (ready_i) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cnt <= '0;
    end else if (w_accept && w_err && !w_cnt_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ready_o   = w_rdy;
  assign valid_o   = r_vld;
  assign bin_o     = r_bin;
  assign err_o     = r_err;
  assign err_cnt_o = r_cnt;

endmodule

// File: tb/tb_one_hot_to_bin_stream.sv
// Directed and randomized checks of one_hot_to_bin_stream against a behavioural model.
module tb_one_hot_to_bin_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] one_hot_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  bin_o;
  logic        err_o;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  err_cnt_o;
  logic        clr_cnt_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_vld;
  int m_bin;
  bit m_err;
  int m_cnt;

  always #5 clk = ~clk;

  one_hot_to_bin_stream #(.ONE_HOT_W(16), .BIN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .one_hot_i(one_hot_i), .valid_i(valid_i),
    .ready_o(ready_o), .bin_o(bin_o), .err_o(err_o), .valid_o(valid_o),
    .ready_i(ready_i), .err_cnt_o(err_cnt_o), .clr_cnt_i(clr_cnt_i)
  );

  function automatic int low_idx(logic [15:0] w);
    logic [15:0] iso;
    iso = w & (~w + 16'd1);
    return (w == 16'd0) ? 0 : $clog2(iso);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid_o"}, int'(valid_o), int'(m_vld));
    chk({tag, ".ready_o"}, int'(ready_o), int'(!m_vld || ready_i));
    chk({tag, ".err_cnt"}, int'(err_cnt_o), m_cnt);
    if (m_vld) begin
      chk({tag, ".bin_o"}, int'(bin_o), m_bin);
      chk({tag, ".err_o"}, int'(err_o), int'(m_err));
    end
  endtask

  // Advance one clock edge, update the model from the pre-edge inputs, then check.
  task automatic step(input string tag);
    bit acc;
    bit bad;
    bit n_vld;
    int n_bin;
    bit n_err;
    int n_cnt;
    acc   = valid_i && (!m_vld || ready_i);
    bad   = ($countones(one_hot_i) != 1);
    n_vld = m_vld;
    n_bin = m_bin;
    n_err = m_err;
    n_cnt = m_cnt;
    if (acc) begin
      n_vld = 1'b1;
      n_bin = low_idx(one_hot_i);
      n_err = bad;
    end else if (ready_i) begin
      n_vld = 1'b0;
    end
    if (clr_cnt_i)            n_cnt = 0;
    else if (acc && bad)      n_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    @(posedge clk);
    #1;
    m_vld = n_vld;
    m_bin = n_bin;
    m_err = n_err;
    m_cnt = n_cnt;
    chk_all(tag);
  endtask

  task automatic drive(input logic [15:0] w, input logic v, input logic r, input logic c);
    one_hot_i = w;
    valid_i   = v;
    ready_i   = r;
    clr_cnt_i = c;
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_bin = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst.valid_o", int'(valid_o), 0);
    chk("rst.bin_o", int'(bin_o), 0);
    chk("rst.err_o", int'(err_o), 0);
    chk("rst.err_cnt", int'(err_cnt_o), 0);
    chk("rst.ready_o", int'(ready_o), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Walking one-hot, back to back
    for (int i = 0; i < 16; i++) begin
      drive(16'h0001 << i, 1'b1, 1'b1, 1'b0);
      step("walk");
    end
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    step("walk_drain");

    // Malformed codes
    drive(16'h0000, 1'b1, 1'b1, 1'b0); step("bad_zero");
    chk("bad_zero.bin", int'(bin_o), 0);
    chk("bad_zero.err", int'(err_o), 1);
    drive(16'h000A, 1'b1, 1'b1, 1'b0); step("bad_0a");
    chk("bad_0a.bin", int'(bin_o), 1);
    drive(16'h8001, 1'b1, 1'b1, 1'b0); step("bad_8001");
    chk("bad_8001.bin", int'(bin_o), 0);
    drive(16'h0000, 1'b0, 1'b1, 1'b0); step("bad_drain");
    chk("bad.cnt3", int'(err_cnt_o), 3);

    // Backpressure hold then simultaneous transfer/accept
    drive(16'h0100, 1'b1, 1'b1, 1'b0); step("bp_load");
    drive(16'h0004, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("bp_hold");
      chk("bp_hold.bin8", int'(bin_o), 8);
      chk("bp_hold.rdy0", int'(ready_o), 0);
    end
    ready_i = 1'b1;
    step("bp_release");
    chk("bp_release.bin2", int'(bin_o), 2);
    drive(16'h0000, 1'b0, 1'b1, 1'b0); step("bp_drain");

    // Saturation
    for (int i = 0; i < 260; i++) begin
      drive(16'h0003, 1'b1, 1'b1, 1'b0);
      step("sat");
    end
    chk("sat.cnt255", int'(err_cnt_o), 255);

    // Clear priority over increment
    drive(16'h0000, 1'b0, 1'b1, 1'b1); step("clr0");
    for (int i = 0; i < 5; i++) begin
      drive(16'h0003, 1'b1, 1'b1, 1'b0);
      step("clr_fill");
    end
    chk("clr.cnt5", int'(err_cnt_o), 5);
    drive(16'h0003, 1'b1, 1'b1, 1'b1); step("clr_same");
    chk("clr_same.cnt0", int'(err_cnt_o), 0);
    chk("clr_same.err1", int'(err_o), 1);

    // Asynchronous reset mid-cycle while output is held
    drive(16'h0040, 1'b1, 1'b1, 1'b0); step("ar_load");
    drive(16'h0002, 1'b1, 1'b0, 1'b0); step("ar_hold");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar.valid_o", int'(valid_o), 0);
    chk("ar.bin_o", int'(bin_o), 0);
    chk("ar.err_cnt", int'(err_cnt_o), 0);
    chk("ar.ready_o", int'(ready_o), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(16'h0020, 1'b1, 1'b1, 1'b0); step("ar_after");
    chk("ar_after.bin5", int'(bin_o), 5);

    // Randomized traffic; input word held while stalled
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (!(valid_i && !ready_o)) begin
        case ($urandom_range(0, 3))
          0:       one_hot_i = 16'($urandom);
          1:       one_hot_i = 16'h0000;
          default: one_hot_i = 16'h0001 << $urandom_range(0, 15);
        endcase
        valid_i = ($urandom_range(0, 3) != 0);
      end
      ready_i   = ($urandom_range(0, 2) != 0);
      clr_cnt_i = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
